snp_bus_ctrl: RTL and testbench



---
 rtl/snp_bus_if.sv | 38 +++
 rtl/snp_bus_ctrl.sv | 114 +++++++++++
 tb/tb_snp_bus_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snp_bus_if.sv
// snp_bus_if: snoop-bus signal bundle between two MESI caches, the controller and memory
interface snp_bus_if #(
    parameter int SADDR_WIDTH = 26,
    parameter int BLK_WIDTH   = 512
);
    logic [2:0]             c0_tx_snp_op,   c1_tx_snp_op;
    logic [SADDR_WIDTH-1:0] c0_tx_snp_addr, c1_tx_snp_addr;
    logic [BLK_WIDTH-1:0]   c0_tx_snp_data, c1_tx_snp_data;
    logic [1:0]             c0_tx_snp_rsp,  c1_tx_snp_rsp;
    logic [2:0]             c0_rx_snp_op,   c1_rx_snp_op;
    logic [SADDR_WIDTH-1:0] c0_rx_snp_addr, c1_rx_snp_addr;
    logic [BLK_WIDTH-1:0]   c0_rx_snp_data, c1_rx_snp_data;
    logic [1:0]             c0_rx_snp_rsp,  c1_rx_snp_rsp;
    logic                   mem_req, mem_we, mem_ack;
    logic [SADDR_WIDTH-1:0] mem_addr;
    logic [BLK_WIDTH-1:0]   mem_wdata, mem_rdata;
    logic                   snp_timeout_err;

    modport slave (
        input  c0_tx_snp_op, c0_tx_snp_addr, c0_tx_snp_data, c0_tx_snp_rsp,
        input  c1_tx_snp_op, c1_tx_snp_addr, c1_tx_snp_data, c1_tx_snp_rsp,
        output c0_rx_snp_op, c0_rx_snp_addr, c0_rx_snp_data, c0_rx_snp_rsp,
        output c1_rx_snp_op, c1_rx_snp_addr, c1_rx_snp_data, c1_rx_snp_rsp,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output snp_timeout_err
    );

    modport master (
        output c0_tx_snp_op, c0_tx_snp_addr, c0_tx_snp_data, c0_tx_snp_rsp,
        output c1_tx_snp_op, c1_tx_snp_addr, c1_tx_snp_data, c1_tx_snp_rsp,
        input  c0_rx_snp_op, c0_rx_snp_addr, c0_rx_snp_data, c0_rx_snp_rsp,
        input  c1_rx_snp_op, c1_rx_snp_addr, c1_rx_snp_data, c1_rx_snp_rsp,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  snp_timeout_err
    );
endinterface

// File: rtl/snp_bus_ctrl.sv
// snp_bus_ctrl: two-cache MESI snoop-bus arbiter, snoop broadcaster and memory sequencer
module snp_bus_ctrl #(
    parameter int SADDR_WIDTH = 26,
    parameter int BLK_WIDTH   = 512,
    parameter int SNP_TIMEOUT = 64
) (
    input logic      clk,
    input logic      rst,
    snp_bus_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, SNOOP = 3'd1, MEM_RD = 3'd2, MEM_WR = 3'd3, DONE = 3'd4, TURN = 3'd5;
    localparam logic [2:0] OP_RD = 3'd1, OP_RDX = 3'd2, OP_UPGR = 3'd3, OP_FLUSH = 3'd4;
    localparam logic [1:0] RSP_OKAY = 2'd1, RSP_SHARED = 2'd2, RSP_DIRTY = 3'd3;
    localparam int CW = $clog2(SNP_TIMEOUT + 1);

    logic [2:0]             state_q, state_d, op_q, op_d;
    logic                   req_q, req_d, rr_last_q, rr_last_d, err_q, err_d;
    logic [SADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BLK_WIDTH-1:0]   data_q, data_d, fill_q, fill_d;
    logic [1:0]             srsp_q, srsp_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0][2:0]             rx_op_q, rx_op_d;
    logic [1:0][SADDR_WIDTH-1:0] rx_addr_q, rx_addr_d;
    logic [1:0][BLK_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [1:0][1:0]             rx_rsp_q, rx_rsp_d;
    logic                   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [SADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BLK_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    // Illegal op codes 5-7 never request the bus
    wire v0  = bus.c0_tx_snp_op != 3'd0 && bus.c0_tx_snp_op <= OP_FLUSH;
    wire v1  = bus.c1_tx_snp_op != 3'd0 && bus.c1_tx_snp_op <= OP_FLUSH;
    wire gnt = v1 && (!v0 || !rr_last_q);
    // The snooped cache is always the one that did not win the grant
    wire [1:0]           srsp_in  = req_q ? bus.c0_tx_snp_rsp : bus.c1_tx_snp_rsp;
    wire [BLK_WIDTH-1:0] sdata_in = req_q ? bus.c0_tx_snp_data : bus.c1_tx_snp_data;
    wire                 tmo      = srsp_in == 2'd0 && cnt_q == CW'(SNP_TIMEOUT - 1);
    wire [1:0]           eff_rsp  = tmo ? RSP_OKAY : srsp_in;
    logic [1:0]          cmp_rsp;
    logic                snp_phase, done_phase;

    // Transaction sequencing plus registered-output next values derived from the next state
    always_comb begin
        state_d = state_q; op_d = op_q; req_d = req_q; rr_last_d = rr_last_q; err_d = err_q;
        addr_d = addr_q; data_d = data_q; fill_d = fill_q; srsp_d = srsp_q;
        case (state_q)
            IDLE: if (v0 || v1) begin
                req_d = gnt; rr_last_d = gnt;
                op_d = gnt ? bus.c1_tx_snp_op : bus.c0_tx_snp_op;
                addr_d = gnt ? bus.c1_tx_snp_addr : bus.c0_tx_snp_addr;
                data_d = gnt ? bus.c1_tx_snp_data : bus.c0_tx_snp_data;
                fill_d = '0; srsp_d = 2'd0;
                state_d = op_d == OP_FLUSH ? MEM_WR : SNOOP;
            end
            SNOOP: if (eff_rsp != 2'd0) begin
                srsp_d = eff_rsp; err_d = err_q | tmo;
                if (op_q == OP_UPGR) state_d = DONE;
                else if (eff_rsp == RSP_DIRTY) begin
                    fill_d = sdata_in; data_d = sdata_in;
                    state_d = op_q == OP_RD ? MEM_WR : DONE;
                end else state_d = MEM_RD;
            end
            MEM_RD: if (bus.mem_ack) begin fill_d = bus.mem_rdata; state_d = DONE; end
            MEM_WR: if (bus.mem_ack) state_d = DONE;
            DONE:   state_d = TURN;
            default: state_d = IDLE;
        endcase
        cnt_d = state_q == SNOOP && state_d == SNOOP ? cnt_q + CW'(1) : '0;
        cmp_rsp = op_d == OP_RD && (srsp_d == RSP_SHARED || srsp_d == RSP_DIRTY) ? RSP_SHARED : RSP_OKAY;
        snp_phase = state_d == SNOOP;
        done_phase = state_d == DONE;
        rx_op_d[0] = snp_phase && req_d ? op_d : 3'd0;
        rx_op_d[1] = snp_phase && !req_d ? op_d : 3'd0;
        rx_addr_d[0] = snp_phase && req_d ? addr_d : '0;
        rx_addr_d[1] = snp_phase && !req_d ? addr_d : '0;
        rx_rsp_d[0] = done_phase && !req_d ? cmp_rsp : 2'd0;
        rx_rsp_d[1] = done_phase && req_d ? cmp_rsp : 2'd0;
        rx_data_d[0] = done_phase && !req_d && (op_d == OP_RD || op_d == OP_RDX) ? fill_d : '0;
        rx_data_d[1] = done_phase && req_d && (op_d == OP_RD || op_d == OP_RDX) ? fill_d : '0;
        mem_req_d = state_d == MEM_RD || state_d == MEM_WR;
        mem_we_d = state_d == MEM_WR;
        mem_addr_d = mem_req_d ? addr_d : '0;
        mem_wdata_d = mem_we_d ? data_d : '0;
    end

    // State and output registers; reset aborts any transaction immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE; op_q <= 3'd0; req_q <= 1'b0; rr_last_q <= 1'b1; err_q <= 1'b0;
            addr_q <= '0; data_q <= '0; fill_q <= '0; srsp_q <= 2'd0; cnt_q <= '0;
            rx_op_q <= '0; rx_addr_q <= '0; rx_data_q <= '0; rx_rsp_q <= '0;
            mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= '0; mem_wdata_q <= '0;
        end else begin
            state_q <= state_d; op_q <= op_d; req_q <= req_d; rr_last_q <= rr_last_d; err_q <= err_d;
            addr_q <= addr_d; data_q <= data_d; fill_q <= fill_d; srsp_q <= srsp_d; cnt_q <= cnt_d;
            rx_op_q <= rx_op_d; rx_addr_q <= rx_addr_d; rx_data_q <= rx_data_d; rx_rsp_q <= rx_rsp_d;
            mem_req_q <= mem_req_d; mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.c0_rx_snp_op = rx_op_q[0];
    assign bus.c1_rx_snp_op = rx_op_q[1];
    assign bus.c0_rx_snp_addr = rx_addr_q[0];
    assign bus.c1_rx_snp_addr = rx_addr_q[1];
    assign bus.c0_rx_snp_data = rx_data_q[0];
    assign bus.c1_rx_snp_data = rx_data_q[1];
    assign bus.c0_rx_snp_rsp = rx_rsp_q[0];
    assign bus.c1_rx_snp_rsp = rx_rsp_q[1];
    assign bus.mem_req = mem_req_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.snp_timeout_err = err_q;
endmodule

// File: tb/tb_snp_bus_ctrl.sv
// tb_snp_bus_ctrl: scoreboard bench with cache and memory responders for snp_bus_ctrl
module tb_snp_bus_ctrl;
    localparam int AW = 26, BW = 512;
    localparam logic [2:0] RD = 3'd1, RDX = 3'd2, UPGR = 3'd3, FLUSH = 3'd4;
    localparam logic [1:0] OKAY = 2'd1, SHARED = 2'd2, DIRTY = 2'd3;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    snp_bus_if #(.SADDR_WIDTH(AW), .BLK_WIDTH(BW)) bus();
    snp_bus_ctrl #(.SADDR_WIDTH(AW), .BLK_WIDTH(BW), .SNP_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [2:0] tx_op[2], rx_op[2];
    logic [AW-1:0] tx_addr[2], rx_addr[2];
    logic [BW-1:0] tx_data[2], rx_data[2];
    logic [1:0] tx_rsp[2], rx_rsp[2];
    logic ack = 1'b0;
    logic [BW-1:0] rdata = '0;
    assign bus.c0_tx_snp_op = tx_op[0];     assign bus.c1_tx_snp_op = tx_op[1];
    assign bus.c0_tx_snp_addr = tx_addr[0]; assign bus.c1_tx_snp_addr = tx_addr[1];
    assign bus.c0_tx_snp_data = tx_data[0]; assign bus.c1_tx_snp_data = tx_data[1];
    assign bus.c0_tx_snp_rsp = tx_rsp[0];   assign bus.c1_tx_snp_rsp = tx_rsp[1];
    assign rx_op[0] = bus.c0_rx_snp_op;     assign rx_op[1] = bus.c1_rx_snp_op;
    assign rx_addr[0] = bus.c0_rx_snp_addr; assign rx_addr[1] = bus.c1_rx_snp_addr;
    assign rx_data[0] = bus.c0_rx_snp_data; assign rx_data[1] = bus.c1_rx_snp_data;
    assign rx_rsp[0] = bus.c0_rx_snp_rsp;   assign rx_rsp[1] = bus.c1_rx_snp_rsp;
    assign bus.mem_ack = ack;
    assign bus.mem_rdata = rdata;

    typedef struct {int c; logic [2:0] op; logic [AW-1:0] addr;} snp_t;
    typedef struct {logic we; logic [AW-1:0] addr; logic [BW-1:0] wdata;} mem_t;
    typedef struct {int c; logic [1:0] rsp; logic [BW-1:0] data;} cmp_t;
    snp_t snp_q[$];
    mem_t mem_q[$];
    cmp_t cmp_q[$];

    int errors = 0, checks = 0;
    logic [1:0] sr_val[2];
    int sr_dly[2], sr_cnt[2];
    logic [BW-1:0] sr_data[2];
    int mem_dly = 1, mcnt = 0;
    logic [BW-1:0] rd_val = '0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input int n, input logic [2:0] op, input logic [AW-1:0] a, input logic [BW-1:0] d);
        tx_addr[n] = a; tx_data[n] = d; tx_op[n] = op;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (tx_op[0] != 0 || tx_op[1] != 0); i++) @(negedge clk);
        checks++;
        if (tx_op[0] != 0 || tx_op[1] != 0) begin
            errors++;
            $display("FAIL completion_timeout: ops still pending %0d %0d expected 0 0", tx_op[0], tx_op[1]);
            tx_op[0] = 0; tx_op[1] = 0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_c0_op"}, rx_op[0], 0);   chk({tag, "_c1_op"}, rx_op[1], 0);
        chk({tag, "_c0_rsp"}, rx_rsp[0], 0); chk({tag, "_c1_rsp"}, rx_rsp[1], 0);
        chk({tag, "_c0_data"}, rx_data[0], 0);
        chk({tag, "_mem_req"}, bus.mem_req, 0); chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_err"}, bus.snp_timeout_err, 0);
    endtask

    // Snooped caches answer with a programmed response after a programmed delay
    initial forever begin
        @(negedge clk);
        for (int n = 0; n < 2; n++)
            if (rx_op[n] != 0) begin
                if (sr_cnt[n] == sr_dly[n] && sr_val[n] != 0) begin
                    tx_rsp[n] = sr_val[n];
                    tx_data[n] = sr_data[n];
                end else sr_cnt[n]++;
            end else begin
                sr_cnt[n] = 0;
                tx_rsp[n] = 0;
            end
    end

    // Memory acknowledges after mem_dly waiting cycles with a one-cycle ack
    initial forever begin
        @(negedge clk);
        if (ack) begin ack = 1'b0; mcnt = 0; end
        else if (bus.mem_req) begin
            if (mcnt == mem_dly) begin ack = 1'b1; rdata = rd_val; end
            else mcnt++;
        end else mcnt = 0;
    end

    // Monitor: pops expectations whenever the DUT presents a snoop, memory request or completion
    initial begin
        logic snp_act[2];
        logic mem_act;
        snp_t cur[2];
        cmp_t ce;
        mem_t me;
        snp_act[0] = 0; snp_act[1] = 0; mem_act = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                snp_act[0] = 0; snp_act[1] = 0; mem_act = 0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (rx_op[n] != 0) begin
                        if (!snp_act[n]) begin
                            snp_act[n] = 1;
                            if (snp_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL unexpected_snoop: got op %0d on cache %0d expected none", rx_op[n], n);
                                cur[n] = '{n, rx_op[n], rx_addr[n]};
                            end else begin
                                cur[n] = snp_q.pop_front();
                                chk("snoop_target", n, cur[n].c);
                            end
                        end
                        chk("snoop_op", rx_op[n], cur[n].op);
                        chk("snoop_addr", rx_addr[n], cur[n].addr);
                    end else snp_act[n] = 0;
                    if (rx_rsp[n] != 0) begin
                        if (cmp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_completion: got rsp %0d on cache %0d expected none", rx_rsp[n], n);
                        end else begin
                            ce = cmp_q.pop_front();
                            chk("cmp_cache", n, ce.c);
                            chk("cmp_rsp", rx_rsp[n], ce.rsp);
                            chk("cmp_data", rx_data[n], ce.data);
                        end
                        tx_op[n] = 0;
                    end
                end
                if (bus.mem_req && !mem_act) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_mem: got addr %0h expected none", bus.mem_addr);
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_we", bus.mem_we, me.we);
                        chk("mem_addr", bus.mem_addr, me.addr);
                        chk("mem_wdata", bus.mem_wdata, me.wdata);
                    end
                end
                mem_act = bus.mem_req;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            tx_op[n] = 0; tx_addr[n] = 0; tx_data[n] = 0; tx_rsp[n] = 0;
            sr_val[n] = OKAY; sr_dly[n] = 1; sr_cnt[n] = 0; sr_data[n] = 0;
        end
        #1 chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Tie right after reset: cache 0 first, each cache snoops the other
        mem_dly = 2; rd_val = {64{8'h11}};
        snp_q.push_back('{1, RDX, 26'h8}); mem_q.push_back('{0, 26'h8, '0}); cmp_q.push_back('{0, OKAY, {64{8'h11}}});
        snp_q.push_back('{0, RDX, 26'h9}); mem_q.push_back('{0, 26'h9, '0}); cmp_q.push_back('{1, OKAY, {64{8'h11}}});
        issue(0, RDX, 26'h8, '0); issue(1, RDX, 26'h9, '0);
        wait_idle();
        chk("err_clear", bus.snp_timeout_err, 0);

        // Plain read, OKAY snoop after 2 cycles, memory fill 0xA5
        sr_val[1] = OKAY; sr_dly[1] = 2; mem_dly = 3; rd_val = {64{8'hA5}};
        snp_q.push_back('{1, RD, 26'h10}); mem_q.push_back('{0, 26'h10, '0}); cmp_q.push_back('{0, OKAY, {64{8'hA5}}});
        issue(0, RD, 26'h10, '0);
        wait_idle();

        // Repeated tie after cache 0 won last: cache 1 goes first; SHARED snoops give SHARED completions
        sr_val[0] = SHARED; sr_val[1] = SHARED; sr_dly[0] = 0; sr_dly[1] = 0; mem_dly = 1; rd_val = {64{8'h22}};
        snp_q.push_back('{0, RD, 26'h13}); mem_q.push_back('{0, 26'h13, '0}); cmp_q.push_back('{1, SHARED, {64{8'h22}}});
        snp_q.push_back('{1, RD, 26'h12}); mem_q.push_back('{0, 26'h12, '0}); cmp_q.push_back('{0, SHARED, {64{8'h22}}});
        issue(0, RD, 26'h12, '0); issue(1, RD, 26'h13, '0);
        wait_idle();

        // Dirty snoop on read: writeback of the dirty block, requester gets SHARED with that data
        sr_val[0] = DIRTY; sr_data[0] = {64{8'h5A}};
        snp_q.push_back('{0, RD, 26'h20}); mem_q.push_back('{1, 26'h20, {64{8'h5A}}}); cmp_q.push_back('{1, SHARED, {64{8'h5A}}});
        issue(1, RD, 26'h20, '0);
        wait_idle();

        // Dirty snoop on RDX: no memory traffic, data forwarded with OKAY
        sr_val[1] = DIRTY; sr_data[1] = {64{8'h3C}};
        snp_q.push_back('{1, RDX, 26'h21}); cmp_q.push_back('{0, OKAY, {64{8'h3C}}});
        issue(0, RDX, 26'h21, '0);
        wait_idle();

        // Upgrade answered SHARED: OKAY without data or memory
        sr_val[0] = SHARED;
        snp_q.push_back('{0, UPGR, 26'h22}); cmp_q.push_back('{1, OKAY, '0});
        issue(1, UPGR, 26'h22, '0);
        wait_idle();

        // Silent snooper: timeout after 64 snoop cycles forces OKAY and sets the sticky error
        sr_val[1] = 2'd0;
        snp_q.push_back('{1, UPGR, 26'h30}); cmp_q.push_back('{0, OKAY, '0});
        issue(0, UPGR, 26'h30, '0);
        repeat (60) @(negedge clk);
        chk("err_before_timeout", bus.snp_timeout_err, 0);
        wait_idle();
        chk("err_after_timeout", bus.snp_timeout_err, 1);

        // Flush: memory write only, no snoop on cache 0
        snp_q.push_back('{0, 3'd0, '0}); snp_q.pop_back();
        mem_q.push_back('{1, 26'h3, {64{8'hFF}}}); cmp_q.push_back('{1, OKAY, '0});
        issue(1, FLUSH, 26'h3, {64{8'hFF}});
        wait_idle();
        chk("err_sticky", bus.snp_timeout_err, 1);

        // Reset while memory read is pending
        sr_val[1] = OKAY; sr_dly[1] = 0; mem_dly = 1000;
        snp_q.push_back('{1, RD, 26'h40}); mem_q.push_back('{0, 26'h40, '0});
        issue(0, RD, 26'h40, '0);
        for (int i = 0; i < 50 && !bus.mem_req; i++) @(negedge clk);
        chk("mem_req_before_rst", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("midrst");
        tx_op[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_dly = 1; rd_val = {64{8'h77}};
        snp_q.push_back('{1, RD, 26'h44}); mem_q.push_back('{0, 26'h44, '0}); cmp_q.push_back('{0, OKAY, {64{8'h77}}});
        issue(0, RD, 26'h44, '0);
        wait_idle();

        chk("snp_q_drained", snp_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("cmp_q_drained", cmp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
